mem_writeback_unit: RTL and testbench

//  Final MEM/WB stage of the multi-cycle RISC-V core; directly upstream of the register file write port.

---
 rtl/mem_wb_pkg.sv | 31 +++
 rtl/load_align.sv | 29 ++
 rtl/mem_writeback_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_writeback_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM/WB stage: FSM states, writeback selects, funct3 codes.
package mem_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when funct3 names a legal access width and the byte offset suits it.
    function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B, F3_BU: access_ok = 1'b1;
            F3_H, F3_HU: access_ok = (off[0] == 1'b0);
            F3_W:        access_ok = (off == 2'b00);
            default:     access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a raw load word and sign- or zero-extends it.
module load_align
    import mem_wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign shifted = rdata >> {off, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_writeback_unit.sv
// MEM/WB stage: performs one data-memory access per retiring instruction and
// pulses the register file write port, retire and fault for a single cycle.
module mem_writeback_unit
    import mem_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic [31:0] in_pc_plus4,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic [4:0]  rd,
    output logic [31:0] rd_din,
    output logic        write_enable,
    output logic        retire,
    output logic        fault
);

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state;
    logic [4:0]       rd_q;
    logic             reg_write_q, mem_read_q, mem_write_q, fault_q;
    logic [2:0]       funct3_q;
    logic [1:0]       wb_sel_q;
    logic [31:0]      alu_q, store_q, pc4_q, load_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept, in_is_mem, in_fault;
    logic             in_req, in_wb;
    logic [31:0]      load_word, wb_value;

    assign accept    = in_valid && (state == IDLE);
    assign in_is_mem = in_mem_read || in_mem_write;
    assign in_fault  = in_is_mem && !access_ok(in_funct3, in_alu_result[1:0]);

    load_align u_load_align (
        .rdata  (mem_resp_rdata),
        .off    (alu_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            fault_q     <= 1'b0;
            funct3_q    <= '0;
            wb_sel_q    <= '0;
            alu_q       <= '0;
            store_q     <= '0;
            pc4_q       <= '0;
            load_q      <= '0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rd_q        <= in_rd;
                    reg_write_q <= in_reg_write;
                    mem_read_q  <= in_mem_read;
                    mem_write_q <= in_mem_write;
                    fault_q     <= in_fault;
                    funct3_q    <= in_funct3;
                    wb_sel_q    <= in_wb_sel;
                    alu_q       <= in_alu_result;
                    store_q     <= in_store_data;
                    pc4_q       <= in_pc_plus4;
                    state       <= (in_is_mem && !in_fault) ? REQ : WB;
                end
                REQ: if (mem_req_ready) begin
                    if (mem_read_q) begin
                        state <= WAIT;
                        cnt_q <= '0;
                    end else begin
                        state <= WB;
                    end
                end
                // A response in the final permitted cycle wins over the timeout.
                WAIT: begin
                    if (mem_resp_valid) begin
                        load_q <= load_word;
                        state  <= WB;
                    end else if (TIMEOUT_CYCLES > 0 && cnt_q == TO_LAST) begin
                        fault_q <= 1'b1;
                        state   <= WB;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign in_req        = (state == REQ);
    assign in_wb         = (state == WB);

    assign mem_req_valid = in_req;
    assign mem_req_we    = in_req && mem_write_q;
    assign mem_req_addr  = in_req ? {alu_q[31:2], 2'b00} : 32'd0;

    always_comb begin
        mem_req_wdata = '0;
        mem_req_wstrb = '0;
        if (in_req && mem_write_q) begin
            case (funct3_q)
                F3_B: begin
                    mem_req_wdata = {4{store_q[7:0]}};
                    mem_req_wstrb = 4'b0001 << alu_q[1:0];
                end
                F3_H: begin
                    mem_req_wdata = {2{store_q[15:0]}};
                    mem_req_wstrb = 4'b0011 << alu_q[1:0];
                end
                default: begin
                    mem_req_wdata = store_q;
                    mem_req_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        case (wb_sel_q)
            WB_MEM:  wb_value = load_q;
            WB_PC4:  wb_value = pc4_q;
            default: wb_value = alu_q;
        endcase
    end

    assign rd           = in_wb ? rd_q : 5'd0;
    assign rd_din       = in_wb ? wb_value : 32'd0;
    assign write_enable = in_wb && reg_write_q && (rd_q != 5'd0) && !fault_q;
    assign retire       = in_wb;
    assign fault        = in_wb && fault_q;

endmodule

// File: tb/tb_mem_writeback_unit.sv
// Directed bench for mem_writeback_unit built with a 4-cycle WAIT timeout.
module tb_mem_writeback_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [31:0] in_pc_plus4;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [4:0]  rd;
    logic [31:0] rd_din;
    logic        write_enable;
    logic        retire;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    mem_writeback_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_funct3      (in_funct3),
        .in_wb_sel      (in_wb_sel),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_pc_plus4    (in_pc_plus4),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .rd             (rd),
        .rd_din         (rd_din),
        .write_enable   (write_enable),
        .retire         (retire),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one instruction for a single accepting edge; returns in the following cycle.
    task automatic issue(input logic [4:0] r, input logic rw, input logic mr, input logic mw,
                         input logic [2:0] f3, input logic [1:0] ws, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [31:0] pc4);
        in_rd         = r;
        in_reg_write  = rw;
        in_mem_read   = mr;
        in_mem_write  = mw;
        in_funct3     = f3;
        in_wb_sel     = ws;
        in_alu_result = alu;
        in_store_data = sd;
        in_pc_plus4   = pc4;
        in_valid      = 1'b1;
        step();
        in_valid      = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_mem_read = 1'b0;
        in_mem_write = 1'b0; in_funct3 = '0; in_wb_sel = '0; in_alu_result = '0;
        in_store_data = '0; in_pc_plus4 = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

        step(); step();
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_retire",    32'(retire), 32'd0);
        chk("rst_we",        32'(write_enable), 32'd0);
        chk("rst_rd_din",    rd_din, 32'd0);
        reset = 1'b1;
        step();

        // Stray memory handshakes while idle must be ignored.
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
        step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        chk("idle_stray_retire", 32'(retire), 32'd0);
        chk("idle_stray_ready",  32'(in_ready), 32'd1);

        // ALU op
        issue(5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0000_1234, 32'd0, 32'd0);
        chk("alu_we",     32'(write_enable), 32'd1);
        chk("alu_rd",     32'(rd), 32'd5);
        chk("alu_rd_din", rd_din, 32'h0000_1234);
        chk("alu_retire", 32'(retire), 32'd1);
        chk("alu_ready",  32'(in_ready), 32'd0);
        chk("alu_fault",  32'(fault), 32'd0);
        step();
        chk("alu_after_retire", 32'(retire), 32'd0);
        chk("alu_after_ready",  32'(in_ready), 32'd1);

        // x0 is never written
        issue(5'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0000_0055, 32'd0, 32'd0);
        chk("x0_retire", 32'(retire), 32'd1);
        chk("x0_we",     32'(write_enable), 32'd0);
        step();

        // PC+4 and reserved select
        issue(5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd2, 32'h0000_0777, 32'd0, 32'h0000_2004);
        chk("pc4_rd_din", rd_din, 32'h0000_2004);
        step();
        issue(5'd2, 1'b1, 1'b0, 1'b0, 3'b000, 2'd3, 32'h0000_0777, 32'd0, 32'h0000_2004);
        chk("sel3_rd_din", rd_din, 32'h0000_0777);
        step();

        // lb 0x103: ready after 2 cycles, response in the 3rd WAIT cycle
        issue(5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 32'h0000_0103, 32'd0, 32'd0);
        chk("lb_req_valid", 32'(mem_req_valid), 32'd1);
        chk("lb_req_addr",  mem_req_addr, 32'h0000_0100);
        chk("lb_req_wstrb", 32'(mem_req_wstrb), 32'd0);
        chk("lb_req_we",    32'(mem_req_we), 32'd0);
        step();
        chk("lb_req_hold",  32'(mem_req_valid), 32'd1);
        step();
        chk("lb_addr_hold", mem_req_addr, 32'h0000_0100);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("lb_wait_req_low", 32'(mem_req_valid), 32'd0);
        step(); step();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h80FF_FF00;
        step();
        mem_resp_valid = 1'b0;
        chk("lb_we",     32'(write_enable), 32'd1);
        chk("lb_rd",     32'(rd), 32'd7);
        chk("lb_rd_din", rd_din, 32'hFFFF_FF80);
        step();

        // lhu / lh at 0x102
        issue(5'd8, 1'b1, 1'b1, 1'b0, 3'b101, 2'd1, 32'h0000_0102, 32'd0, 32'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBEEF_0000;
        step();
        mem_resp_valid = 1'b0;
        chk("lhu_rd_din", rd_din, 32'h0000_BEEF);
        chk("lhu_we",     32'(write_enable), 32'd1);
        step();
        issue(5'd8, 1'b1, 1'b1, 1'b0, 3'b001, 2'd1, 32'h0000_0102, 32'd0, 32'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBEEF_0000;
        step();
        mem_resp_valid = 1'b0;
        chk("lh_rd_din", rd_din, 32'hFFFF_BEEF);
        step();

        // sh 0x206
        issue(5'd3, 1'b0, 1'b0, 1'b1, 3'b001, 2'd0, 32'h0000_0206, 32'h0000_ABCD, 32'd0);
        chk("sh_we_req", 32'(mem_req_we), 32'd1);
        chk("sh_addr",   mem_req_addr, 32'h0000_0204);
        chk("sh_wstrb",  32'(mem_req_wstrb), 32'h0000_000C);
        chk("sh_wdata",  mem_req_wdata, 32'hABCD_ABCD);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("sh_retire", 32'(retire), 32'd1);
        chk("sh_we",     32'(write_enable), 32'd0);
        chk("sh_fault",  32'(fault), 32'd0);
        step();

        // sb 0x301
        issue(5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 32'h0000_0301, 32'h1234_5678, 32'd0);
        chk("sb_wstrb", 32'(mem_req_wstrb), 32'h0000_0002);
        chk("sb_wdata", mem_req_wdata, 32'h7878_7878);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();

        // Misaligned lw: no request, immediate faulted retire
        issue(5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h0000_0101, 32'd0, 32'd0);
        chk("mis_req_valid", 32'(mem_req_valid), 32'd0);
        chk("mis_fault",     32'(fault), 32'd1);
        chk("mis_retire",    32'(retire), 32'd1);
        chk("mis_we",        32'(write_enable), 32'd0);
        step();

        // Illegal funct3 on a memory op
        issue(5'd9, 1'b1, 1'b1, 1'b0, 3'b011, 2'd1, 32'h0000_0100, 32'd0, 32'd0);
        chk("ill_fault", 32'(fault), 32'd1);
        step();

        // Timeout after 4 WAIT cycles
        issue(5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h0000_0200, 32'd0, 32'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step(); step(); step();
        chk("to_w4_retire", 32'(retire), 32'd0);
        step();
        chk("to_fault",  32'(fault), 32'd1);
        chk("to_retire", 32'(retire), 32'd1);
        chk("to_we",     32'(write_enable), 32'd0);
        step();

        // Reset during WAIT, then a late response
        issue(5'd11, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h0000_0300, 32'd0, 32'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("rstw_in_ready", 32'(in_ready), 32'd1);
        step();
        reset = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_2222;
        step();
        mem_resp_valid = 1'b0;
        chk("rstw_we",     32'(write_enable), 32'd0);
        chk("rstw_retire", 32'(retire), 32'd0);
        chk("rstw_ready",  32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
